// File: rtl/ex_stage_pkg.sv
// ex_stage_pkg: shared op codes, load/store kinds and divider state encodings for the execute stage
package ex_stage_pkg;
  typedef enum logic [4:0] {
    ALU_NOP, ALU_ADD, ALU_SUB, ALU_SLL, ALU_SRL, ALU_SRA, ALU_SLT, ALU_SLTU,
    ALU_AND, ALU_OR, ALU_XOR, ALU_LUI, ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU
  } alu_sel_e;
  typedef enum logic [2:0] {NO_LOAD, LD_LB, LD_LH, LD_LW, LD_LBU, LD_LHU} load_e;
  typedef enum logic [2:0] {NO_STORE, ST_SB, ST_SH, ST_SW} store_e;
  typedef enum logic [1:0] {DIV_IDLE, DIV_BUSY, DIV_DONE} div_state_e;
  function automatic logic is_div(input logic [4:0] s);
    return s == ALU_DIV || s == ALU_DIVU || s == ALU_REM || s == ALU_REMU;
  endfunction
  function automatic logic is_signed_div(input logic [4:0] s);
    return s == ALU_DIV || s == ALU_REM;
  endfunction
endpackage

// File: rtl/ex_divider.sv
// ex_divider: radix-2 restoring divider; in: start, op1/op2, op; out: busy, done, result (sign-fixed)
module ex_divider
  import ex_stage_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int DIV_CYCLES = XLEN
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [XLEN-1:0] op1,
  input  logic [XLEN-1:0] op2,
  input  logic [4:0]      op,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);
  localparam int CW = $clog2(DIV_CYCLES);
  div_state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0] rem_q, rem_d, quo_q, quo_d, dsr_q, dsr_d;
  logic neg_q_q, neg_q_d, neg_r_q, neg_r_d, is_rem_q, is_rem_d;
  logic s1, s2, ge;
  logic [XLEN:0] rem_sh, diff;
  always_comb begin
    s1 = is_signed_div(op) && op1[XLEN-1];
    s2 = is_signed_div(op) && op2[XLEN-1];
    rem_sh = {rem_q, quo_q[XLEN-1]};
    diff = rem_sh - {1'b0, dsr_q};
    ge = rem_sh >= {1'b0, dsr_q};
    state_d = state_q;
    cnt_d = cnt_q;
    rem_d = rem_q;
    quo_d = quo_q;
    dsr_d = dsr_q;
    neg_q_d = neg_q_q;
    neg_r_d = neg_r_q;
    is_rem_d = is_rem_q;
    case (state_q)
      DIV_IDLE: if (start) begin
        state_d = DIV_BUSY;
        cnt_d = '0;
        rem_d = '0;
        quo_d = s1 ? -op1 : op1;
        dsr_d = s2 ? -op2 : op2;
        neg_q_d = s1 ^ s2;
        neg_r_d = s1;
        is_rem_d = op == ALU_REM || op == ALU_REMU;
      end
      DIV_BUSY: begin
        quo_d = {quo_q[XLEN-2:0], ge};
        rem_d = ge ? diff[XLEN-1:0] : rem_sh[XLEN-1:0];
        cnt_d = cnt_q + 1'b1;
        state_d = cnt_q == CW'(DIV_CYCLES - 1) ? DIV_DONE : DIV_BUSY;
      end
      default: state_d = DIV_IDLE;
    endcase
    busy = state_q == DIV_BUSY;
    done = state_q == DIV_DONE;
    result = is_rem_q ? (neg_r_q ? -rem_q : rem_q) : (neg_q_q ? -quo_q : quo_q);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= DIV_IDLE;
      cnt_q <= '0;
      rem_q <= '0;
      quo_q <= '0;
      dsr_q <= '0;
      neg_q_q <= 1'b0;
      neg_r_q <= 1'b0;
      is_rem_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      rem_q <= rem_d;
      quo_q <= quo_d;
      dsr_q <= dsr_d;
      neg_q_q <= neg_q_d;
      neg_r_q <= neg_r_d;
      is_rem_q <= is_rem_d;
    end
  end
endmodule

// File: rtl/ex_stage.sv
// ex_stage: RV32IM execute stage; in: ID/EX op, operands, tags, MEM/WB writebacks; out: result/address, passthroughs, forwarded store data, stall request
module ex_stage
  import ex_stage_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int DIV_CYCLES = XLEN
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [4:0]      alusel,
  input  logic [XLEN-1:0] s1data,
  input  logic [XLEN-1:0] s2data,
  input  logic            fromreg1,
  input  logic            fromreg2,
  input  logic [4:0]      reg1addr,
  input  logic            reg1en,
  input  logic [4:0]      reg2addr,
  input  logic            reg2en,
  input  logic [4:0]      rd,
  input  logic            regwe,
  input  logic [2:0]      loadctl,
  input  logic [2:0]      storectl,
  input  logic [XLEN-1:0] storedata,
  input  logic [4:0]      mem_rd,
  input  logic            mem_regwe,
  input  logic [XLEN-1:0] mem_wdata,
  input  logic [4:0]      wb_rd,
  input  logic            wb_regwe,
  input  logic [XLEN-1:0] wb_wdata,
  output logic [XLEN-1:0] wdata_o,
  output logic [4:0]      rd_o,
  output logic            regwe_o,
  output logic [2:0]      loadctl_o,
  output logic [2:0]      storectl_o,
  output logic [XLEN-1:0] storedata_o,
  output logic            stallreq_o
);
  logic [XLEN-1:0] op1, op2, st, alu, div_res, spec_res;
  logic dz, ovf, start, busy, done, ls;
  function automatic logic [XLEN-1:0] fwd(input logic en, input logic [4:0] a, input logic [XLEN-1:0] base);
    return !(en && a != 5'd0) ? base : (mem_regwe && mem_rd == a) ? mem_wdata :
           (wb_regwe && wb_rd == a) ? wb_wdata : base;
  endfunction
  always_comb begin
    op1 = fwd(fromreg1 && reg1en, reg1addr, s1data);
    op2 = fwd(fromreg2 && reg2en, reg2addr, s2data);
    st = fwd(reg2en, reg2addr, storedata);
    dz = op2 == '0;
    ovf = is_signed_div(alusel) && op1 == {1'b1, {(XLEN-1){1'b0}}} && op2 == '1;
    spec_res = (alusel == ALU_REM || alusel == ALU_REMU) ? (dz ? op1 : '0) : (dz ? '1 : op1);
    start = is_div(alusel) && !dz && !ovf;
    ls = loadctl != NO_LOAD || storectl != NO_STORE;
    case (alusel)
      ALU_ADD:  alu = op1 + op2;
      ALU_SUB:  alu = op1 - op2;
      ALU_SLL:  alu = op1 << op2[4:0];
      ALU_SRL:  alu = op1 >> op2[4:0];
      ALU_SRA:  alu = $signed(op1) >>> op2[4:0];
      ALU_SLT:  alu = {{(XLEN-1){1'b0}}, $signed(op1) < $signed(op2)};
      ALU_SLTU: alu = {{(XLEN-1){1'b0}}, op1 < op2};
      ALU_AND:  alu = op1 & op2;
      ALU_OR:   alu = op1 | op2;
      ALU_XOR:  alu = op1 ^ op2;
      ALU_LUI:  alu = op2;
      default:  alu = '0;
    endcase
    // In DONE the live operands may no longer match the latched ones, so only the divider result counts
    wdata_o = rst ? '0 : ls ? op1 + op2 : is_div(alusel) ? (done ? div_res : spec_res) : alu;
    rd_o = rst ? 5'd0 : rd;
    regwe_o = !rst && regwe;
    loadctl_o = rst ? NO_LOAD : loadctl;
    storectl_o = rst ? NO_STORE : storectl;
    storedata_o = rst ? '0 : storectl != NO_STORE ? st : storedata;
    stallreq_o = !rst && (busy || (start && !done));
  end
  ex_divider #(.XLEN(XLEN), .DIV_CYCLES(DIV_CYCLES)) u_div (
    .clk(clk),
    .rst(rst),
    .start(start),
    .op1(op1),
    .op2(op2),
    .op(alusel),
    .busy(busy),
    .done(done),
    .result(div_res)
  );
endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: directed-vector bench for ex_stage with a behavioural reference model
module tb_ex_stage;
  import ex_stage_pkg::*;
  logic clk = 1'b0, rst = 1'b0;
  logic [4:0] alusel, reg1addr, reg2addr, rd, mem_rd, wb_rd, rd_o;
  logic [31:0] s1data, s2data, storedata, mem_wdata, wb_wdata, wdata_o, storedata_o;
  logic fromreg1, fromreg2, reg1en, reg2en, regwe, mem_regwe, wb_regwe, regwe_o, stallreq_o;
  logic [2:0] loadctl, storectl, loadctl_o, storectl_o;
  int checks = 0, errors = 0;
  logic chk_en = 1'b0, chk_w = 1'b0, exp_st = 1'b0;
  logic [31:0] exp_w = '0, esd;
  string tag = "";
  always #5 clk = ~clk;
  ex_stage dut (
    .clk(clk), .rst(rst), .alusel(alusel), .s1data(s1data), .s2data(s2data),
    .fromreg1(fromreg1), .fromreg2(fromreg2), .reg1addr(reg1addr), .reg1en(reg1en),
    .reg2addr(reg2addr), .reg2en(reg2en), .rd(rd), .regwe(regwe), .loadctl(loadctl),
    .storectl(storectl), .storedata(storedata), .mem_rd(mem_rd), .mem_regwe(mem_regwe),
    .mem_wdata(mem_wdata), .wb_rd(wb_rd), .wb_regwe(wb_regwe), .wb_wdata(wb_wdata),
    .wdata_o(wdata_o), .rd_o(rd_o), .regwe_o(regwe_o), .loadctl_o(loadctl_o),
    .storectl_o(storectl_o), .storedata_o(storedata_o), .stallreq_o(stallreq_o)
  );
  // Youngest in-flight writer of a nonzero forwardable register wins
  function automatic logic [31:0] fwdm(input logic ok, input logic [4:0] a, input logic [31:0] base);
    if (!ok || a == 5'd0) return base;
    if (mem_regwe && mem_rd == a) return mem_wdata;
    if (wb_regwe && wb_rd == a) return wb_wdata;
    return base;
  endfunction
  function automatic logic [31:0] model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b, input logic ls);
    int sa, sb;
    sa = a;
    sb = b;
    if (ls) return a + b;
    case (op)
      ALU_ADD:  return a + b;
      ALU_SUB:  return a - b;
      ALU_SLL:  return a << b[4:0];
      ALU_SRL:  return a >> b[4:0];
      ALU_SRA:  return 32'(sa >>> b[4:0]);
      ALU_SLT:  return {31'd0, sa < sb};
      ALU_SLTU: return {31'd0, a < b};
      ALU_AND:  return a & b;
      ALU_OR:   return a | b;
      ALU_XOR:  return a ^ b;
      ALU_LUI:  return b;
      ALU_DIV:  return b == 0 ? 32'hFFFFFFFF : (a == 32'h80000000 && b == 32'hFFFFFFFF) ? a : 32'(sa / sb);
      ALU_DIVU: return b == 0 ? 32'hFFFFFFFF : a / b;
      ALU_REM:  return b == 0 ? a : (a == 32'h80000000 && b == 32'hFFFFFFFF) ? 32'd0 : 32'(sa % sb);
      ALU_REMU: return b == 0 ? a : a % b;
      default:  return 32'd0;
    endcase
  endfunction
  function automatic logic [31:0] model_now();
    return model(alusel, fwdm(fromreg1 && reg1en, reg1addr, s1data), fwdm(fromreg2 && reg2en, reg2addr, s2data),
                 loadctl != 3'd0 || storectl != 3'd0);
  endfunction
  always @(negedge clk) if (chk_en) begin
    esd = rst ? 32'd0 : storectl != 3'd0 ? fwdm(reg2en, reg2addr, storedata) : storedata;
    checks += 3;
    if (stallreq_o !== exp_st) begin
      errors++;
      $display("FAIL %s stallreq: got %b expected %b", tag, stallreq_o, exp_st);
    end
    if (rd_o !== (rst ? 5'd0 : rd) || regwe_o !== (!rst && regwe) || loadctl_o !== (rst ? 3'd0 : loadctl) ||
        storectl_o !== (rst ? 3'd0 : storectl)) begin
      errors++;
      $display("FAIL %s passthru: got rd=%0d we=%b ld=%0d st=%0d", tag, rd_o, regwe_o, loadctl_o, storectl_o);
    end
    if (storedata_o !== esd) begin
      errors++;
      $display("FAIL %s storedata: got %h expected %h", tag, storedata_o, esd);
    end
    if (chk_w) begin
      checks++;
      if (wdata_o !== exp_w) begin
        errors++;
        $display("FAIL %s wdata: got %h expected %h", tag, wdata_o, exp_w);
      end
    end
  end
  task automatic setop(input logic [4:0] s, input logic [31:0] a, input logic [31:0] b);
    alusel = s; s1data = a; s2data = b;
    fromreg1 = 0; fromreg2 = 0; reg1addr = 0; reg2addr = 0; reg1en = 0; reg2en = 0;
    rd = 5'd1; regwe = 1; loadctl = 0; storectl = 0; storedata = 32'h5A5A0000;
    mem_rd = 0; mem_regwe = 0; mem_wdata = 0; wb_rd = 0; wb_regwe = 0; wb_wdata = 0;
  endtask
  task automatic pin(input string name, input logic [31:0] m, input logic [31:0] lit);
    checks++;
    if (m !== lit) begin
      errors++;
      $display("FAIL model %s: model %h literal %h", name, m, lit);
    end
  endtask
  task automatic run_alu(input string name, input logic [31:0] lit);
    logic [31:0] m;
    m = model_now();
    pin(name, m, lit);
    tag = name; exp_w = m; exp_st = 0; chk_w = 1; chk_en = 1;
    @(posedge clk); #1;
  endtask
  task automatic run_div(input string name, input logic [31:0] lit, input logic chg, input logic [31:0] nv);
    logic [31:0] m;
    m = model_now();
    pin(name, m, lit);
    tag = name; exp_w = m; chk_en = 1;
    for (int k = 0; k < 34; k++) begin
      if (chg && k == 1) wb_wdata = nv;
      exp_st = k <= 32;
      chk_w = k == 33;
      @(posedge clk); #1;
    end
  endtask
  initial begin
    setop(ALU_ADD, 32'd3, 32'd4);
    rd = 5'd5; storectl = 3'd3; storedata = 32'd7; loadctl = 3'd3;
    rst = 1;
    tag = "reset"; exp_w = 0; exp_st = 0; chk_w = 1; chk_en = 1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 0;
    setop(ALU_ADD, 32'd100, 32'd3);
    fromreg1 = 1; reg1en = 1; reg1addr = 5'd5;
    mem_rd = 5'd5; mem_regwe = 1; mem_wdata = 32'd7; wb_rd = 5'd5; wb_regwe = 1; wb_wdata = 32'd9;
    run_alu("add_fwd_mem", 32'd10);
    mem_regwe = 0;
    run_alu("add_fwd_wb", 32'd12);
    setop(ALU_ADD, 32'h20, 32'd3);
    fromreg1 = 1; reg1en = 1; mem_regwe = 1; mem_wdata = 32'h55;
    run_alu("x0_no_fwd", 32'h23);
    reg1addr = 5'd5; mem_rd = 5'd5; fromreg1 = 0;
    run_alu("imm_no_fwd", 32'h23);
    setop(ALU_SUB, 32'd5, 32'd7);       run_alu("sub", 32'hFFFFFFFE);
    setop(ALU_SLL, 32'd3, 32'd36);      run_alu("sll", 32'd48);
    setop(ALU_SRL, 32'h80000000, 32'd4); run_alu("srl", 32'h08000000);
    setop(ALU_SRA, 32'h80000000, 32'd33); run_alu("sra", 32'hC0000000);
    setop(ALU_SLT, 32'hFFFFFFFF, 32'd1); run_alu("slt", 32'd1);
    setop(ALU_SLTU, 32'hFFFFFFFF, 32'd1); run_alu("sltu", 32'd0);
    setop(ALU_XOR, 32'hF0F0, 32'hFF00); run_alu("xor", 32'h0FF0);
    setop(ALU_AND, 32'hF0F0, 32'hFF00); run_alu("and", 32'hF000);
    setop(ALU_OR, 32'hF0F0, 32'hFF00);  run_alu("or", 32'hFFF0);
    setop(ALU_LUI, 32'd9, 32'h12345000); run_alu("lui", 32'h12345000);
    setop(ALU_NOP, 32'd9, 32'd9);       run_alu("nop", 32'd0);
    setop(ALU_ADD, 32'h1000, 32'd8);
    storectl = 3'd3; storedata = 32'h11; reg2en = 1; reg2addr = 5'd6;
    mem_rd = 5'd6; mem_regwe = 1; mem_wdata = 32'hAB;
    run_alu("sw_fwd", 32'h1008);
    setop(ALU_ADD, 32'hFFFFFFFC, 32'd8); loadctl = 3'd3; run_alu("lw_addr", 32'd4);
    setop(ALU_DIVU, 32'd5, 32'd0);      run_alu("divu_zero", 32'hFFFFFFFF);
    setop(ALU_REMU, 32'd5, 32'd0);      run_alu("remu_zero", 32'd5);
    setop(ALU_DIV, 32'h80000000, 32'hFFFFFFFF); run_alu("div_ovf", 32'h80000000);
    setop(ALU_REM, 32'h80000000, 32'hFFFFFFFF); run_alu("rem_ovf", 32'd0);
    setop(ALU_DIV, 32'hFFFFFFF9, 32'd2); run_div("div_m7_2", 32'hFFFFFFFD, 0, 0);
    setop(ALU_REM, 32'hFFFFFFF9, 32'd2); run_div("rem_m7_2", 32'hFFFFFFFF, 0, 0);
    setop(ALU_DIVU, 32'd100, 32'd7);    run_div("divu_100_7", 32'd14, 0, 0);
    setop(ALU_REM, 32'd100, 32'hFFFFFFF9); run_div("rem_100_m7", 32'd2, 0, 0);
    setop(ALU_DIVU, 32'd1, 32'd5);
    fromreg1 = 1; reg1en = 1; reg1addr = 5'd3; wb_rd = 5'd3; wb_regwe = 1; wb_wdata = 32'd50;
    run_div("div_latch", 32'd10, 1, 32'd90);
    setop(ALU_DIV, 32'd100, 32'd3);
    tag = "div_rst"; chk_w = 0; chk_en = 1;
    for (int k = 0; k < 10; k++) begin
      exp_st = 1;
      @(posedge clk); #1;
    end
    rst = 1; exp_st = 0; exp_w = 0; chk_w = 1;
    @(posedge clk); #1;
    rst = 0;
    setop(ALU_ADD, 32'd1, 32'd1);
    run_alu("add_after_rst", 32'd2);
    chk_en = 0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/ex_stage.md
# ex_stage

Execute stage of the 5-stage RV32IM core, directly downstream of the ID/EX pipeline register. It takes the registered operation, operands and forwarding tags, and resolves operand forwarding from the MEM and WB stages. It computes ALU results in one cycle and DIV/DIVU/REM/REMU over 33 cycles in an iterative radix-2 divider. While the divider is busy it raises `stallreq_o` so the stall controller freezes PC through EX and bubbles MEM.

## Interface
Parameters:
- `XLEN`, 32, datapath width
- `DIV_CYCLES`, 32, divider iterations; fixed to `XLEN`

Ports. Reset is asynchronous and active-high.
- `clk`  in  1  clock
- `rst`  in  1  reset, asynchronous, active-high
- `alusel`  in  `AluSelBus` (5)  operation code
- `s1data`, `s2data`  in  32  operands from ID/EX (immediate or register value)
- `fromreg1`, `fromreg2`  in  1  operand came from a register, so it is forwardable
- `reg1addr`/`reg1en`, `reg2addr`/`reg2en`  in  5/1  source register tags
- `rd`, `regwe`  in  5/1  destination
- `loadctl`, `storectl`  in  `LSBus` (3)  load/store kind
- `storedata`  in  32  store value from ID
- `mem_rd`, `mem_regwe`, `mem_wdata`  in  5/1/32  MEM-stage writeback
- `wb_rd`, `wb_regwe`, `wb_wdata`  in  5/1/32  WB-stage writeback
- `wdata_o`  out  32  result, or address for load/store
- `rd_o`, `regwe_o`  out  5/1  destination passthrough
- `loadctl_o`, `storectl_o`  out  3  passthrough
- `storedata_o`  out  32  forwarded store value
- `stallreq_o`  out  1  EX stall request to the stall controller

## Operation
- **Forwarding, per operand:**
  - Forward only if `fromregN && regNen && regNaddr != 0`.
  - Source priority: MEM match (`mem_regwe && mem_rd == addr`), then WB match, then the ID/EX value.
  - `storedata_o` uses the rs2 forward path whenever `storectl != NoStore`.
  - Load-use hazards are resolved in ID; EX never sees a MEM-stage load feeding it.
- **ALU, combinational:**
  - ADD, SUB, SLL, SRL, SRA use shift amount = operand2[4:0].
  - SLT is signed, SLTU unsigned.
  - AND, OR, XOR; LUI passes operand2.
  - NOP yields 0.
  - Loads and stores: `wdata_o` = op1 + op2, mod 2^32.
- **Divider FSM:**
  - States: IDLE, BUSY, DONE.
  - IDLE → BUSY on a DIV-family `alusel` when no special case applies. At this transition the forwarded operands, signs and op kind are latched. A forwarded source may leave the pipe during the stall, so the live inputs are not reused.
  - Operands are converted to magnitudes; the counter is cleared.
  - BUSY: one restoring shift-subtract step per cycle. Counter 0..31; at 31 the FSM moves to DONE.
  - DONE: apply signs. Quotient sign = sign1 XOR sign2 (signed ops only); remainder sign = sign1. Drive `wdata_o` from the latched result, then return to IDLE.
- **Special cases, same cycle, no stall:**
  - Divisor = 0: quotient = 0xFFFFFFFF; remainder = dividend.
  - Signed 0x80000000 / 0xFFFFFFFF: quotient = 0x80000000; remainder = 0.
- **`stallreq_o`:**
  - High combinationally in IDLE when a non-special divide is presented.
  - High throughout BUSY; low in DONE.

## Timing
- ALU ops and divide special cases: result on the same cycle they sit in EX. Zero added latency.
- Normal divide, cycle 0 = the cycle the op is in EX: cycles 0–32 stall, result valid in cycle 33. EX occupancy is 34 cycles.
- During the stall, ID/EX holds its contents because stall[2] and stall[3] are both high. EX outputs are don't-care while stalled; the controller bubbles MEM.
- Back-to-back divides: the second starts from IDLE in the cycle after DONE.
- **Reset:** asynchronous.
  - FSM → IDLE; counter and divider registers → 0.
  - While `rst` is high all outputs are forced: `wdata_o` = 0, `rd_o` = 0, `regwe_o` = 0, `loadctl_o` = NoLoad, `storectl_o` = NoStore, `storedata_o` = 0, `stallreq_o` = 0.
  - Reset mid-divide aborts the divide with no result.

## Structure
- Shared package `define.vh` gains: `AluDiv`, `AluDivu`, `AluRem`, `AluRemu` codes; `DivStateBus` and the IDLE/BUSY/DONE encodings.
- Sub-module `ex_divider`: owns the FSM, counter and sign fixup. Interface: start, operands, op, outputs busy/done/result.
- Forwarding muxes and the ALU live in `ex_stage`.

## Test plan
- ADD: rs1 = x5 forwarded from MEM (`mem_wdata` = 7), WB also writes x5 = 9, op2 imm = 3 → `wdata_o` = 10, `stallreq_o` = 0.
- Forward suppression: `reg1addr` = 0 with `mem_rd` = 0, `mem_wdata` = 0x55 → ID/EX value used. Same check with `fromreg1` = 0.
- DIV −7 / 2 → `stallreq_o` high cycles 0–32, cycle 33 `wdata_o` = 0xFFFFFFFD. REM → 0xFFFFFFFF. DIVU 100 / 7 → 14.
- DIVU x / 0 → 0xFFFFFFFF same cycle, no stall. DIV 0x80000000 / −1 → 0x80000000; REM → 0.
- Divide latches a WB-forwarded operand at cycle 0; WB data changes in cycle 1 → result still uses the cycle-0 value.
- Assert `rst` in BUSY cycle 10 → `stallreq_o` = 0 immediately; next op ADD 1 + 1 after reset → 2 with no stall.
